// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and defaults for the multi-channel clock divider
package clk_div_pkg;

    localparam int CNT_W_DEF = 32;

    typedef logic [CNT_W_DEF-1:0] div_cnt_t;

    typedef struct packed {
        div_cnt_t cnt;
        div_cnt_t active_div;
        div_cnt_t pending_div;
        logic     pend_valid;
        logic     outclk;
    } chan_state_t;

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel (counter, shadow divisor, toggle flop); optional MULTI_CHAN_CLK_DIV_PHASE_EN adds a sync phase preload
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             sync,
    input  logic [CNT_W-1:0] div_in,
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
    input  logic [CNT_W-1:0] phase_off,
`endif
    output logic             outclk,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
    logic             pv_q, pv_d, out_q, out_d, tick_q, tick_d;
    logic             wrap;

    // Next state: sync or a disabled channel applies divisors immediately; a running channel only at its wrap
    always_comb begin
        wrap   = cnt_q == act_q;
        cnt_d  = '0;
        act_d  = act_q;
        pend_d = load ? div_in : pend_q;
        pv_d   = 1'b0;
        out_d  = 1'b0;
        tick_d = 1'b0;
        if (sync || !en) begin
            act_d = load ? div_in : (pv_q ? pend_q : act_q);
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
            cnt_d = (sync && en) ? (phase_off < act_d ? phase_off : act_d) : '0;
`endif
        end else begin
            cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
            act_d  = (wrap && pv_q) ? pend_q : act_q;
            pv_d   = load | (pv_q & ~wrap);
            out_d  = out_q ^ wrap;
            tick_d = wrap;
        end
    end

    // Channel state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            act_q  <= DEFAULT_DIV;
            pend_q <= DEFAULT_DIV;
            pv_q   <= 1'b0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign outclk = out_q;
    assign tick   = tick_q;

endmodule

// File: rtl/multi_chan_clk_div.sv
// multi_chan_clk_div: NUM_CH independent glitch-free clock dividers; optional MULTI_CHAN_CLK_DIV_PHASE_EN adds phase_off
module multi_chan_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 0
) (
    input  logic                    inclk,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] div_count,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync,
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
    input  logic [NUM_CH*CNT_W-1:0] phase_off,
`endif
    output logic [NUM_CH-1:0]       outclk,
    output logic [NUM_CH-1:0]       outclk_not,
    output logic [NUM_CH-1:0]       tick
);

    assign outclk_not = ~outclk;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(CNT_W'(DEFAULT_DIV))
        ) u_chan (
            .clk      (inclk),
            .rst_n    (Reset),
            .en       (ch_en[i]),
            .load     (load[i]),
            .sync     (sync),
            .div_in   (div_count[i*CNT_W +: CNT_W]),
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
            .phase_off(phase_off[i*CNT_W +: CNT_W]),
`endif
            .outclk   (outclk[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_chan_clk_div.sv
// tb_multi_chan_clk_div: scoreboard bench for multi_chan_clk_div against a countdown reference model
module tb_multi_chan_clk_div;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int DEF = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   ch_en = '0;
    logic [N-1:0]   load = '0;
    logic [N*W-1:0] div_count = '0;
    logic           sync = 1'b0;
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
    logic [N*W-1:0] phase_off = '0;
`endif
    logic [N-1:0]   outclk, outclk_not, tick;

    always #5 clk = ~clk;

    multi_chan_clk_div #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
        .inclk     (clk),
        .Reset     (rst_n),
        .ch_en     (ch_en),
        .div_count (div_count),
        .load      (load),
        .sync      (sync),
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
        .phase_off (phase_off),
`endif
        .outclk    (outclk),
        .outclk_not(outclk_not),
        .tick      (tick)
    );

    typedef struct {
        logic [N-1:0] o;
        logic [N-1:0] t;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           act[N], pend[N], left[N];
    bit           pv[N];
    logic [N-1:0] m_out, m_tick;

    task automatic check(string name, logic [N-1:0] got, logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", name, got, want, $time);
        end
    endtask

    // Reference: each channel counts down the edges left in its current half period
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            act[i]  = DEF;
            pend[i] = DEF;
            pv[i]   = 1'b0;
            left[i] = DEF + 1;
        end
        m_out  = '0;
        m_tick = '0;
        sb.delete();
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            int d;
            d = int'(div_count[i*W +: W]);
            if (sync || !ch_en[i]) begin
                act[i] = load[i] ? d : (pv[i] ? pend[i] : act[i]);
                if (load[i]) pend[i] = d;
                pv[i]     = 1'b0;
                m_out[i]  = 1'b0;
                m_tick[i] = 1'b0;
                left[i]   = act[i] + 1;
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
                if (sync && ch_en[i]) begin
                    int off;
                    off = int'(phase_off[i*W +: W]);
                    left[i] -= (off < act[i]) ? off : act[i];
                end
`endif
            end else begin
                left[i]--;
                m_tick[i] = (left[i] == 0);
                if (left[i] == 0) begin
                    m_out[i] = ~m_out[i];
                    if (pv[i]) act[i] = pend[i];
                    pv[i]   = 1'b0;
                    left[i] = act[i] + 1;
                end
                if (load[i]) begin
                    pend[i] = d;
                    pv[i]   = 1'b1;
                end
            end
        end
        sb.push_back('{m_out, m_tick});
    endtask

    task automatic set_div(int i, int d);
        div_count[i*W +: W] = W'(d);
    endtask

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            load = '0;
            sync = 1'b0;
        end
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest expected response
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("outclk", outclk, e.o);
            check("outclk_not", outclk_not, ~e.o);
            check("tick", tick, e.t);
        end
    end

    initial begin
        model_reset();
        #12;
        check("rst_outclk", outclk, '0);
        check("rst_outclk_not", outclk_not, '1);
        check("rst_tick", tick, '0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        // single channel, div 4, and div 0 on channel 1 loaded while disabled
        set_div(0, 4);
        set_div(1, 0);
        load = 4'b0011;
        cyc();
        ch_en = 4'b0001;
        cyc(30);
        ch_en = 4'b0011;
        cyc(10);
        // divisor changes on a running channel wait for the wrap
        set_div(0, 9);
        load = 4'b0001;
        cyc();
        cyc(27);
        set_div(0, 2);
        load = 4'b0001;
        cyc();
        cyc(30);
        // four channels at divs 1..4, then a phase-aligning sync
        for (int i = 0; i < N; i++) set_div(i, i + 1);
        load  = 4'b1111;
        ch_en = 4'b1111;
        cyc(20 + $urandom_range(0, 7));
        sync = 1'b1;
        cyc();
        cyc(12);
        // randomized traffic
        repeat (500) begin
            if ($urandom_range(0, 9) == 0) ch_en[$urandom_range(0, N-1)] ^= 1'b1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) begin
                    set_div(i, $urandom_range(0, 6));
                    load[i] = 1'b1;
                end
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
                phase_off[i*W +: W] = W'($urandom_range(0, 8));
`endif
            end
            sync = ($urandom_range(0, 39) == 0);
            cyc();
        end
        // asynchronous reset between edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_outclk", outclk, '0);
        check("async_outclk_not", outclk_not, '1);
        check("async_tick", tick, '0);
        model_reset();
        cyc(3);
        ch_en = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(30);
`ifdef MULTI_CHAN_CLK_DIV_PHASE_EN
        set_div(0, 7);
        load = 4'b0001;
        ch_en = 4'b0000;
        cyc();
        ch_en = 4'b0001;
        phase_off[0 +: W] = W'(5);
        cyc(4);
        sync = 1'b1;
        cyc();
        cyc(24);
`endif
        cyc(2);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
